timer_ctrl: RTL and testbench

- Memory-mapped timer controller on the single-cycle ARM data bus, replacing the ad-hoc timestamp/trigger words in dmem.
- Software programs a compare value, starts a one-shot or periodic count, and polls or takes an interrupt on expiry.
- Sequences the counting resource: prescaled ticks, run/expire FSM, sticky status, write-1-to-clear.
- Same clock as the processor. The top-level address decode drives sel; this block does not decode addresses.

---
 rtl/timer_ctrl.sv | 136 +++++++++++++
 tb/tb_timer_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Bus-mapped timer: prescaled COUNT runs up to LOAD, then raises a sticky DONE in
// one-shot or periodic mode. Registers: CTRL, LOAD, COUNT (read-only) and STATUS (write 1 to clear).
`timescale 1ns/1ps
module timer_ctrl #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       a,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic             irq
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_EXPIRED
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_mode;
    logic             r_ie;
    logic             r_done;
    logic [WIDTH-1:0] r_load;
    logic [WIDTH-1:0] r_count;
    logic [PW-1:0]    r_pre;

    logic             w_wr_ctrl;
    logic             w_wr_load;
    logic             w_wr_stat;
    logic             w_run;
    logic             w_start;
    logic             w_stop;
    logic             w_tick;
    logic             w_expire;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_limit;

    assign w_wr_ctrl = sel & we & (a == 2'd0);
    assign w_wr_load = sel & we & (a == 2'd1);
    assign w_wr_stat = sel & we & (a == 2'd3);
    assign w_run     = (r_state == S_RUN);
    assign w_start   = w_wr_ctrl & wd[0] & ~w_run;
    assign w_stop    = w_wr_ctrl & ~wd[0] & w_run;

    // A software stop on a tick edge wins: the count freezes and no expiry is taken.
    assign w_tick    = w_run & ~w_stop & (r_pre == PMAX);
    assign w_next    = r_count + WIDTH'(1);
    assign w_limit   = (r_load == '0) ? WIDTH'(1) : r_load;
    assign w_expire  = w_tick & (w_next >= w_limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_expire && !r_mode) begin
                    w_state_nxt = S_EXPIRED;
                end
            end
            default: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode  <= 1'b0;
            r_ie    <= 1'b0;
            r_done  <= 1'b0;
            r_load  <= '0;
            r_count <= '0;
            r_pre   <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_mode <= wd[1];
                r_ie   <= wd[2];
            end
            if (w_wr_load) begin
                r_load <= wd;
            end

            if (w_start) begin
                r_count <= '0;
                r_pre   <= '0;
            end else if (w_stop) begin
                r_pre   <= '0;
            end else if (w_run) begin
                r_pre <= w_tick ? '0 : r_pre + PW'(1);
                if (w_tick) begin
                    r_count <= (w_expire && r_mode) ? '0 : w_next;
                end
            end

            // Hardware set beats a same-edge software clear so no expiry is lost.
            if (w_expire) begin
                r_done <= 1'b1;
            end else if (w_wr_stat && wd[0]) begin
                r_done <= 1'b0;
            end
        end
    end

    always_comb begin
        rd = '0;
        case (a)
            2'd0:    rd[2:0] = {r_ie, r_mode, w_run};
            2'd1:    rd      = r_load;
            2'd2:    rd      = r_count;
            default: rd[0]   = r_done;
        endcase
    end

    assign irq = r_done & r_ie;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios checked against hand-derived values,
// then random bus traffic checked against an event-level reference model.
`timescale 1ns/1ps
module tb_timer_ctrl;
    localparam int W = 32;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         sel, we;
    logic [1:0]   a;
    logic [W-1:0] wd, rd;
    logic         irq;
    logic         sel1, we1;
    logic [1:0]   a1;
    logic [W-1:0] wd1, rd1;
    logic         irq1;

    always #5 clk = ~clk;

    timer_ctrl #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we), .a(a), .wd(wd), .rd(rd), .irq(irq)
    );

    timer_ctrl #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .sel(sel1), .we(we1), .a(a1), .wd(wd1), .rd(rd1), .irq(irq1)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: run flag, elapsed edges since start, architectural registers.
    bit           m_run, m_mode, m_ie, m_done;
    logic [W-1:0] m_load, m_count;
    int           m_elapsed;

    task automatic model_reset();
        m_run = 0; m_mode = 0; m_ie = 0; m_done = 0;
        m_load = '0; m_count = '0; m_elapsed = 0;
    endtask

    function automatic logic [W-1:0] model_rd(input logic [1:0] aa);
        case (aa)
            2'd0:    return W'({m_ie, m_mode, m_run});
            2'd1:    return m_load;
            2'd2:    return m_count;
            default: return W'(m_done);
        endcase
    endfunction

    task automatic model_edge(input bit s, input bit w, input logic [1:0] aa, input logic [W-1:0] d);
        bit           wr;
        bit           hit;
        logic [W:0]   lim;
        wr  = s && w;
        hit = 0;
        lim = (m_load == 0) ? (W+1)'(1) : {1'b0, m_load};
        if (wr && aa == 0 && d[0] && !m_run) begin
            m_run = 1; m_count = '0; m_elapsed = 0;
        end else if (wr && aa == 0 && !d[0] && m_run) begin
            m_run = 0;
        end else if (m_run) begin
            m_elapsed++;
            if (m_elapsed % P == 0) begin
                if ({1'b0, m_count} + (W+1)'(1) >= lim) begin
                    hit = 1;
                    if (m_mode) m_count = '0;
                    else begin
                        m_count = m_count + 1;
                        m_run   = 0;
                    end
                end else begin
                    m_count = m_count + 1;
                end
            end
        end
        if (wr && aa == 0) begin
            m_mode = d[1];
            m_ie   = d[2];
        end
        if (wr && aa == 1) m_load = d;
        if (hit) m_done = 1;
        else if (wr && aa == 3 && d[0]) m_done = 0;
    endtask

    // One bus cycle on the main DUT; the model advances on the same edge.
    task automatic bus(input bit s, input bit w, input logic [1:0] aa, input logic [W-1:0] d);
        sel = s; we = w; a = aa; wd = d;
        @(posedge clk);
        model_edge(s, w, aa, d);
        #1;
        sel = 0; we = 0;
    endtask

    task automatic peek(input logic [1:0] aa, output logic [W-1:0] v);
        a = aa;
        #1;
        v = rd;
    endtask

    task automatic peek1(input logic [1:0] aa, output logic [W-1:0] v);
        a1 = aa;
        #1;
        v = rd1;
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), v);
            vectors++;
            if (v !== '0) begin
                miscompares++;
                $display("FAIL reset_reg%0d: got %0h expected 0", i, v);
            end
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        reset = 1'b1;
        #2;
        bus(1, 1, 2'd2, 5);
        peek(2'd2, v);
        vectors++;
        if (v !== '0) begin
            miscompares++;
            $display("FAIL count_readonly: got %0h expected 0", v);
        end
    endtask

    task automatic test_oneshot();
        logic [W-1:0] v;
        int           ec;
        bit           ed;
        bus(1, 1, 2'd1, 3);
        bus(1, 1, 2'd0, 5);
        for (int k = 1; k <= 52; k++) begin
            bus(0, 0, 2'd0, 0);
            ed = (k >= 12);
            ec = ed ? 3 : k / 4;
            peek(2'd2, v);
            vectors++;
            if (v !== W'(ec)) begin
                miscompares++;
                $display("FAIL oneshot_count k=%0d: got %0d expected %0d", k, v, ec);
            end
            peek(2'd3, v);
            vectors++;
            if (v !== W'(ed)) begin
                miscompares++;
                $display("FAIL oneshot_done k=%0d: got %0d expected %0d", k, v, ed);
            end
            peek(2'd0, v);
            vectors++;
            if (v !== (ed ? W'(4) : W'(5))) begin
                miscompares++;
                $display("FAIL oneshot_ctrl k=%0d: got %0h expected %0h", k, v, ed ? 4 : 5);
            end
            vectors++;
            if (irq !== ed) begin
                miscompares++;
                $display("FAIL oneshot_irq k=%0d: got %b expected %b", k, irq, ed);
            end
        end
        bus(1, 1, 2'd3, 1);
    endtask

    task automatic test_periodic();
        logic [W-1:0] v;
        bit           ed;
        bus(1, 1, 2'd1, 2);
        bus(1, 1, 2'd0, 3);
        for (int k = 1; k <= 20; k++) begin
            if (k == 10) bus(1, 1, 2'd3, 1);
            else         bus(0, 0, 2'd0, 0);
            ed = (k >= 8 && k < 10) || k >= 16;
            peek(2'd2, v);
            vectors++;
            if (v !== W'((k / 4) % 2)) begin
                miscompares++;
                $display("FAIL periodic_count k=%0d: got %0d expected %0d", k, v, (k / 4) % 2);
            end
            peek(2'd3, v);
            vectors++;
            if (v !== W'(ed)) begin
                miscompares++;
                $display("FAIL periodic_done k=%0d: got %0d expected %0d", k, v, ed);
            end
        end
        bus(1, 1, 2'd0, 0);
        bus(1, 1, 2'd3, 1);
    endtask

    task automatic test_same_edge();
        logic [W-1:0] v;
        bus(1, 1, 2'd1, 2);
        bus(1, 1, 2'd0, 3);
        for (int k = 1; k <= 7; k++) bus(0, 0, 2'd0, 0);
        peek(2'd3, v);
        vectors++;
        if (v !== '0) begin
            miscompares++;
            $display("FAIL same_edge_pre: got %0d expected 0", v);
        end
        bus(1, 1, 2'd3, 1);
        peek(2'd3, v);
        vectors++;
        if (v !== W'(1)) begin
            miscompares++;
            $display("FAIL same_edge_done: got %0d expected 1", v);
        end
        bus(1, 1, 2'd0, 0);
        bus(1, 1, 2'd3, 1);
    endtask

    task automatic test_mid_run();
        logic [W-1:0] v;
        bus(1, 1, 2'd1, 10);
        bus(1, 1, 2'd0, 1);
        for (int k = 1; k <= 24; k++) bus(0, 0, 2'd0, 0);
        peek(2'd2, v);
        vectors++;
        if (v !== W'(6)) begin
            miscompares++;
            $display("FAIL midrun_count6: got %0d expected 6", v);
        end
        bus(1, 1, 2'd1, 4);
        bus(0, 0, 2'd0, 0);
        bus(0, 0, 2'd0, 0);
        peek(2'd3, v);
        vectors++;
        if (v !== '0) begin
            miscompares++;
            $display("FAIL midrun_early_done: got %0d expected 0", v);
        end
        bus(0, 0, 2'd0, 0);
        peek(2'd2, v);
        vectors++;
        if (v !== W'(7)) begin
            miscompares++;
            $display("FAIL midrun_count7: got %0d expected 7", v);
        end
        peek(2'd3, v);
        vectors++;
        if (v !== W'(1)) begin
            miscompares++;
            $display("FAIL midrun_done: got %0d expected 1", v);
        end
        bus(1, 1, 2'd3, 1);

        bus(1, 1, 2'd1, 10);
        bus(1, 1, 2'd0, 1);
        for (int k = 1; k <= 12; k++) bus(0, 0, 2'd0, 0);
        bus(1, 1, 2'd0, 0);
        for (int k = 0; k < 20; k++) begin
            bus(0, 0, 2'd0, 0);
            peek(2'd2, v);
            vectors++;
            if (v !== W'(3)) begin
                miscompares++;
                $display("FAIL stop_hold k=%0d: got %0d expected 3", k, v);
            end
        end
        bus(1, 1, 2'd0, 1);
        peek(2'd2, v);
        vectors++;
        if (v !== '0) begin
            miscompares++;
            $display("FAIL restart_zero: got %0d expected 0", v);
        end
        for (int k = 1; k <= 4; k++) bus(0, 0, 2'd0, 0);
        peek(2'd2, v);
        vectors++;
        if (v !== W'(1)) begin
            miscompares++;
            $display("FAIL restart_tick: got %0d expected 1", v);
        end
        bus(1, 1, 2'd0, 0);
    endtask

    task automatic test_load0();
        logic [W-1:0] v;
        a1 = 2'd1; wd1 = '0; sel1 = 1; we1 = 1;
        @(posedge clk);
        #1;
        a1 = 2'd0; wd1 = 5;
        @(posedge clk);
        #1;
        sel1 = 0; we1 = 0;
        peek1(2'd2, v);
        vectors++;
        if (v !== '0) begin
            miscompares++;
            $display("FAIL load0_start: got %0d expected 0", v);
        end
        @(posedge clk);
        #1;
        peek1(2'd2, v);
        vectors++;
        if (v !== W'(1)) begin
            miscompares++;
            $display("FAIL load0_count: got %0d expected 1", v);
        end
        peek1(2'd3, v);
        vectors++;
        if (v !== W'(1)) begin
            miscompares++;
            $display("FAIL load0_done: got %0d expected 1", v);
        end
        vectors++;
        if (irq1 !== 1'b1) begin
            miscompares++;
            $display("FAIL load0_irq: got %b expected 1", irq1);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] v;
        bus(1, 1, 2'd1, 2);
        bus(1, 1, 2'd0, 7);
        for (int k = 1; k <= 9; k++) bus(0, 0, 2'd0, 0);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL prereset_irq: got %b expected 1", irq);
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), v);
            vectors++;
            if (v !== '0) begin
                miscompares++;
                $display("FAIL async_reset_reg%0d: got %0h expected 0", i, v);
            end
        end
        vectors++;
        if (irq !== 1'b0 || irq1 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_irq: got %b/%b expected 0/0", irq, irq1);
        end
        #1;
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        int           r;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8)
                bus(1, 1, 2'd0, W'({$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                    $urandom_range(0, 9) < 7}));
            else if (r < 14) bus(1, 1, 2'd1, W'($urandom_range(0, 12)));
            else if (r < 20) bus(1, 1, 2'd3, W'($urandom_range(0, 3)));
            else if (r < 22) bus(1, 1, 2'd2, $urandom);
            else if (r < 25) bus(0, 1, 2'($urandom_range(0, 3)), W'($urandom_range(0, 7)));
            else             bus($urandom_range(0, 1) == 1, 0, 2'd0, $urandom);
            for (int i = 0; i < 4; i++) begin
                peek(2'(i), v);
                vectors++;
                if (v !== model_rd(2'(i))) begin
                    miscompares++;
                    $display("FAIL random_reg%0d n=%0d: got %0h expected %0h", i, n, v, model_rd(2'(i)));
                end
            end
            vectors++;
            if (irq !== (m_done & m_ie)) begin
                miscompares++;
                $display("FAIL random_irq n=%0d: got %b expected %b", n, irq, m_done & m_ie);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        sel = 0; we = 0; a = '0; wd = '0;
        sel1 = 0; we1 = 0; a1 = '0; wd1 = '0;
        #12;
        test_reset();
        test_oneshot();
        test_periodic();
        test_same_edge();
        test_mid_run();
        test_load0();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
